cog_vidx: RTL and testbench
===========================

# cog_vidx

Parametrised, single-clock successor to the cog video generator. A DEPTH-entry pixel/colour FIFO with a valid/ready handshake decouples cog WAITVID issue from frame timing. It adds a 2 bpp palette mode, an 8 bpp direct mode and sticky underrun detection, and drives a configurable-width pin group. It sits between the cog's WAITVID/VCFG/VSCL datapath and the pin OR-bus; the pixel rate is set by a clock-enable tick from the PLL domain.

## Interface
- PIN_WIDTH, 32, width of pin_out; multiple of 8.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CNT_WIDTH, 8, width of the pixel-clocks-per-pixel counter.
- SET_WIDTH, 12, width of the pixel-clocks-per-frame counter.
- clk_cog  in  1  sole clock.
- res  in  1  reset; synchronous, active-high.
- vid_tick  in  1  pixel-clock enable; all shifter state advances only when high.
- setvid  in  1  load vid from data.
- setscl  in  1  load scl from data[CNT_WIDTH+SET_WIDTH-1:0].
- data  in  32  configuration word.
- push  in  1  WAITVID word valid.
- pixel  in  32  pixel word.
- color  in  32  four colour bytes.
- ready  out  1  FIFO can accept; a word transfers when push && ready.
- underrun  out  1  sticky: a frame boundary found the FIFO empty.
- pin_out  out  PIN_WIDTH  masked video byte placed in the selected byte group.

## Operation
- **vid fields:**
  - vid[30:29]: nonzero means RUN, 00 means IDLE.
  - vid[28:27]: mode. 00 = 1 bpp palette; 01 = 2 bpp palette; 10 = 8 bpp direct; 11 behaves as 00.
  - vid[7:0]: pin mask.
  - vid[G+7:8]: byte group, where G = clog2(PIN_WIDTH/8), minimum 1 bit. A group index beyond the range yields pin_out = 0.
- **scl fields:** scl[CNT_WIDTH+SET_WIDTH-1:SET_WIDTH] = clocks per pixel (cpp); scl[SET_WIDTH-1:0] = clocks per frame (cpf). A value of 0 means 2^width.
- **IDLE:**
  - FIFO flushed, count = 0.
  - set counter = 1, pixel counter = 1.
  - pixels, colors and discrete = 0.
  - ready = 0; pin_out = 0.
- **RUN:**
  - ready = (count < DEPTH), registered from count.
  - push && ready writes {pixel, color} at the tail.
- **On each vid_tick in RUN:**
  - **Frame boundary (set == 1):**
    - set <= cpf and cnt <= cpp.
    - If the FIFO is not empty: pop the head into pixels/colors.
    - If the FIFO is empty: pixels <= 0, colors <= 0, underrun <= 1.
  - **Else, pixel boundary (cnt == 1):**
    - cnt <= cpp.
    - pixels shifts right, zero-fill, by 1, 2 or 8 bits for modes 00, 01, 10.
    - set decrements.
  - **Otherwise:** cnt and set both decrement.
  - **discrete (registered every vid_tick):**
    - mode 00: colour byte selected by pixels[0].
    - mode 01: colour byte selected by pixels[1:0].
    - mode 10: pixels[7:0].
- pin_out = ({discrete & vid[7:0]}) << (8 × group), zero-extended to PIN_WIDTH. It is combinational from registers and is 0 in IDLE.
- **Clearing underrun:** any setvid clears it. When setvid and an underrun event coincide, the set wins.
- **Push and pop in the same cycle:** count is unchanged and both take effect. A pop never sees a word pushed in the same cycle; an empty FIFO underruns even if push is high.
- **Entering IDLE:** writing vid[30:29] = 00 mid-frame enters IDLE on the next edge and discards queued words.
- **Reconfiguring:** setscl mid-frame takes effect at the next reload of the counter concerned.

## Timing
- Reset values: vid = 0, scl = 0, FIFO empty, ready = 0, underrun = 0, pin_out = 0, all counters = 1.
- setvid to RUN to ready = 1: one clk_cog edge.
- Push to FIFO-visible: one edge.
- Pop on tick N: the first pixel value appears in discrete/pin_out after tick N+1.
- Each pixel is held cpp ticks. The frame lasts cpf ticks regardless of how many pixels remain; bits not shifted out are dropped.
- ready falls the edge after the DEPTH-th accepted push and rises the edge after a pop from full.

## Test plan
- **Reset, then 1 bpp:**
  - Stimulus: res, vid = 0x2000_00FF, scl cpp = 1, cpf = 32, push pixel = 0x0000_0005, color = 0x0000_AA55.
  - Required: pin_out[7:0] sequence 0xAA, 0x55, 0xAA, 0x55, then 0x55 for the remaining 28 ticks.
- **2 bpp with mask and group:**
  - Stimulus: vid = 0x2800_020F (group 2, mask 0x0F), pixels = 0xE4, color = 0x4433_2211, cpp = 2.
  - Required: pin_out = 0x0001_0000, 0x0002_0000, 0x0003_0000, 0x0004_0000, each held 2 ticks.
- **8 bpp direct:**
  - Stimulus: vid mode 10, pixel = 0x1234_5678, cpf = 4.
  - Required: bytes 0x78, 0x56, 0x34, 0x12 on consecutive ticks; color ignored.
- **FIFO full and back-pressure:**
  - Stimulus: DEPTH = 4, no vid_tick, 5 consecutive pushes.
  - Required: ready drops after the 4th; the 5th word is not stored. Once ticks run, the 4 words emerge in order.
- **Underrun:**
  - Stimulus: one word pushed, cpf = 8, 16 ticks.
  - Required: the second frame outputs 0 and underrun = 1. A subsequent setvid clears it.
- **Disable mid-frame:**
  - Stimulus: vid = 0 while 3 words are queued.
  - Required: next edge pin_out = 0, ready = 0, count = 0. On re-enable the first tick pops newly pushed data only.

Source files
------------

// File: rtl/cog_vidx.sv
// cog_vidx: FIFO-decoupled cog video generator with 1/2 bpp palette and 8 bpp direct modes.
// Shifter state advances on vid_tick; pin_out places the masked video byte into one byte group.
module cog_vidx #(
  parameter int PIN_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SET_WIDTH = 12
) (
  input  logic                 clk_cog,
  input  logic                 res,
  input  logic                 vid_tick,
  input  logic                 setvid,
  input  logic                 setscl,
  input  logic [31:0]          data,
  input  logic                 push,
  input  logic [31:0]          pixel,
  input  logic [31:0]          color,
  output logic                 ready,
  output logic                 underrun,
  output logic [PIN_WIDTH-1:0] pin_out
);

  localparam int NGRP = PIN_WIDTH / 8;
  localparam int G    = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int SW   = CNT_WIDTH + SET_WIDTH;

  // Mode 11 falls into the default (1 bpp) arm of both helpers.
  function automatic logic [7:0] vid_byte(input logic [1:0] mode, input logic [31:0] pix,
                                          input logic [31:0] col);
    logic [7:0] b;
    case (mode)
      2'b01:   b = col[{pix[1:0], 3'b000} +: 8];
      2'b10:   b = pix[7:0];
      default: b = col[{pix[0], 3'b000} +: 8];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] shift_pix(input logic [1:0] mode, input logic [31:0] pix);
    logic [31:0] s;
    case (mode)
      2'b01:   s = pix >> 2;
      2'b10:   s = pix >> 8;
      default: s = pix >> 1;
    endcase
    return s;
  endfunction

  logic                 run_q, run_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           mask_q, mask_d;
  logic [G-1:0]         grp_q, grp_d;
  logic [SW-1:0]        scl_q, scl_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 underrun_q, underrun_d;
  logic [SET_WIDTH-1:0] set_q, set_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          pixels_q, pixels_d;
  logic [31:0]          colors_q, colors_d;
  logic [7:0]           discrete_q, discrete_d;
  logic [63:0]          mem_q [DEPTH];

  logic                 wr_en;
  logic                 pop;
  logic                 uflow;
  logic [63:0]          head;
  logic [CNT_WIDTH-1:0] cpp;
  logic [SET_WIDTH-1:0] cpf;
  logic                 unused_data;

  assign unused_data = ^data;
  // A counter value of 0 stands for 2^width: decrementing it wraps to 2^width-1.
  assign cpp = scl_q[SW-1:SET_WIDTH];
  assign cpf = scl_q[SET_WIDTH-1:0];

  always_comb begin
    run_d      = run_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    grp_d      = grp_q;
    scl_d      = scl_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    set_d      = set_q;
    cnt_d      = cnt_q;
    pixels_d   = pixels_q;
    colors_d   = colors_q;
    discrete_d = discrete_q;
    pop        = 1'b0;
    uflow      = 1'b0;
    wr_en      = run_q & push & ready_q;
    head       = mem_q[rd_ptr_q];

    if (setvid) begin
      run_d  = |data[30:29];
      mode_d = data[28:27];
      mask_d = data[7:0];
      grp_d  = data[G+7:8];
    end
    if (setscl) begin
      scl_d = data[SW-1:0];
    end

    if (run_q && vid_tick) begin
      discrete_d = vid_byte(mode_q, pixels_q, colors_q);
      if (set_q == SET_WIDTH'(1)) begin
        set_d = cpf;
        cnt_d = cpp;
        // Pop uses the registered count, so a same-cycle push cannot rescue an empty FIFO.
        if (count_q != '0) begin
          pop      = 1'b1;
          pixels_d = head[63:32];
          colors_d = head[31:0];
        end else begin
          pixels_d = '0;
          colors_d = '0;
          uflow    = 1'b1;
        end
      end else if (cnt_q == CNT_WIDTH'(1)) begin
        cnt_d    = cpp;
        pixels_d = shift_pix(mode_q, pixels_q);
        set_d    = set_q - SET_WIDTH'(1);
      end else begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        set_d = set_q - SET_WIDTH'(1);
      end
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    underrun_d = setvid ? 1'b0 : (underrun_q | uflow);

    // Leaving RUN (or staying idle) flushes the queue and parks the shifter.
    if (!run_d) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      set_d      = SET_WIDTH'(1);
      cnt_d      = CNT_WIDTH'(1);
      pixels_d   = '0;
      colors_d   = '0;
      discrete_d = '0;
    end
    ready_d = run_d && (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      run_q      <= 1'b0;
      mode_q     <= '0;
      mask_q     <= '0;
      grp_q      <= '0;
      scl_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      set_q      <= SET_WIDTH'(1);
      cnt_q      <= CNT_WIDTH'(1);
    end else begin
      run_q      <= run_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      grp_q      <= grp_d;
      scl_q      <= scl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      set_q      <= set_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_cog) begin
    pixels_q   <= pixels_d;
    colors_q   <= colors_d;
    discrete_q <= discrete_d;
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {pixel, color};
    end
  end

  // Groups beyond NGRP never match, so an out-of-range group yields zero.
  always_comb begin
    pin_out = '0;
    if (run_q) begin
      for (int g = 0; g < NGRP; g++) begin
        if (grp_q == G'(g)) begin
          pin_out[8*g +: 8] = discrete_q & mask_q;
        end
      end
    end
  end

  assign ready    = ready_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_cog_vidx.sv
// Self-checking bench for cog_vidx: directed scenarios plus randomized runs against a frame-level model.
module tb_cog_vidx;

  logic        clk_cog = 1'b0;
  logic        res = 1'b1;
  logic        vid_tick = 1'b0;
  logic        setvid = 1'b0;
  logic        setscl = 1'b0;
  logic [31:0] data = '0;
  logic        push = 1'b0;
  logic [31:0] pixel = '0;
  logic [31:0] color = '0;
  logic        ready;
  logic        underrun;
  logic [31:0] pin_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_cog = ~clk_cog;

  cog_vidx #(.PIN_WIDTH(32), .DEPTH(4), .CNT_WIDTH(8), .SET_WIDTH(12)) dut (
    .clk_cog (clk_cog),
    .res     (res),
    .vid_tick(vid_tick),
    .setvid  (setvid),
    .setscl  (setscl),
    .data    (data),
    .push    (push),
    .pixel   (pixel),
    .color   (color),
    .ready   (ready),
    .underrun(underrun),
    .pin_out (pin_out)
  );

  // Frame-level reference: tick m=0 is the first boundary after enable, word f fills frame f.
  int          m_mode, m_cpp, m_cpf, m_k, m_grp;
  logic [7:0]  m_mask;
  logic [31:0] m_pix [4];
  logic [31:0] m_col [4];

  function automatic logic [31:0] model_pin(int m);
    int f, j, idx, sel;
    logic [31:0] p, c;
    logic [7:0]  b;
    if (m <= 0) return 32'h0;
    f = (m - 1) / m_cpf;
    j = (m - 1) % m_cpf;
    idx = j / m_cpp;
    p = '0;
    c = '0;
    if (f < m_k) begin
      p = m_pix[f];
      c = m_col[f];
    end
    sel = 0;
    if (m_mode == 2) begin
      b = (idx < 4) ? p[8*idx +: 8] : 8'h00;
    end else begin
      if (m_mode == 1) sel = (idx < 16) ? int'(p[2*idx +: 2]) : 0;
      else             sel = (idx < 32) ? int'(p[idx]) : 0;
      b = c[8*sel +: 8];
    end
    return {24'h0, b & m_mask} << (8 * m_grp);
  endfunction

  function automatic logic model_underrun(int m);
    if (m < 0) return 1'b0;
    return (m / m_cpf + 1) > m_k;
  endfunction

  function automatic logic model_ready(int m);
    int done;
    done = (m < 0) ? 0 : (m / m_cpf + 1);
    if (done > m_k) done = m_k;
    return (m_k - done) < 4;
  endfunction

  task automatic cyc();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic set_vid(input logic [31:0] v);
    setvid = 1'b1;
    data = v;
    cyc();
    setvid = 1'b0;
    data = '0;
  endtask

  task automatic set_scl(input int cpp, input int cpf);
    setscl = 1'b1;
    data = ((cpp & 32'hFF) << 12) | (cpf & 32'hFFF);
    cyc();
    setscl = 1'b0;
    data = '0;
  endtask

  task automatic push_word(input logic [31:0] p, input logic [31:0] c);
    push = 1'b1;
    pixel = p;
    color = c;
    cyc();
    push = 1'b0;
  endtask

  task automatic tick();
    vid_tick = 1'b1;
    cyc();
    vid_tick = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    cyc();
    cyc();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL reset_pin: got %h expected %h", pin_out, 32'h0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    res = 1'b0;
    cyc();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", ready); end
  endtask

  task automatic test_1bpp();
    logic [7:0] e;
    set_vid(32'h0);
    set_scl(1, 32);
    set_vid(32'h2000_00FF);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL 1bpp_ready: got %b expected 1", ready); end
    push_word(32'h0000_0005, 32'h0000_AA55);
    tick();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL 1bpp_pop: got %h expected 0", pin_out); end
    for (int i = 0; i < 32; i++) begin
      tick();
      e = (i < 4 && (i % 2) == 0) ? 8'hAA : 8'h55;
      checks++; if (pin_out !== {24'h0, e}) begin errors++; $display("FAIL 1bpp_px%0d: got %h expected %h", i, pin_out, {24'h0, e}); end
      if (i == 30) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL 1bpp_early_underrun: got %b expected 0", underrun); end
      end
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL 1bpp_underrun: got %b expected 1", underrun); end
    tick();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL 1bpp_empty: got %h expected 0", pin_out); end
  endtask

  task automatic test_2bpp();
    logic [31:0] e;
    set_vid(32'h0);
    set_scl(2, 16);
    set_vid(32'h2800_020F);
    push_word(32'h0000_00E4, 32'h4433_2211);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i / 2 + 1) << 16;
      checks++; if (pin_out !== e) begin errors++; $display("FAIL 2bpp_t%0d: got %h expected %h", i, pin_out, e); end
    end
  endtask

  task automatic test_8bpp();
    logic [7:0] e8 [4];
    e8 = '{8'h78, 8'h56, 8'h34, 8'h12};
    set_vid(32'h0);
    set_scl(1, 4);
    set_vid(32'h3000_00FF);
    push_word(32'h1234_5678, 32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pin_out !== {24'h0, e8[i]}) begin errors++; $display("FAIL 8bpp_b%0d: got %h expected %h", i, pin_out, {24'h0, e8[i]}); end
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] w [5];
    logic [31:0] e;
    for (int i = 0; i < 5; i++) w[i] = $urandom | 32'h0101_0101;
    set_vid(32'h0);
    set_scl(1, 4);
    set_vid(32'h3000_00FF);
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      pixel = w[i];
      color = $urandom;
      cyc();
      checks++; if (ready !== (i < 3)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", i, ready, (i < 3)); end
    end
    push = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %b expected 1", ready); end
    for (int wi = 0; wi < 4; wi++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        e = {24'h0, w[wi][8*b +: 8]};
        checks++; if (pin_out !== e) begin errors++; $display("FAIL full_w%0d_b%0d: got %h expected %h", wi, b, pin_out, e); end
      end
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL full_underrun: got %b expected 1", underrun); end
    tick();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL full_fifth_dropped: got %h expected 0", pin_out); end
  endtask

  task automatic test_underrun();
    set_vid(32'h0);
    set_scl(1, 8);
    set_vid(32'h2000_00FF);
    push_word($urandom, 32'h5A5A_5A5A);
    for (int m = 0; m <= 8; m++) begin
      tick();
      if (m == 7) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_before: got %b expected 0", underrun); end
      end
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b expected 1", underrun); end
    for (int m = 9; m <= 15; m++) begin
      tick();
      checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL ur_zero_t%0d: got %h expected 0", m, pin_out); end
    end
    set_vid(32'h2000_00FF);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
    setvid = 1'b1;
    data = 32'h2000_00FF;
    vid_tick = 1'b1;
    cyc();
    setvid = 1'b0;
    vid_tick = 1'b0;
    data = '0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_set_wins: got %b expected 0", underrun); end
    for (int m = 17; m <= 24; m++) tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_again: got %b expected 1", underrun); end
  endtask

  task automatic test_disable();
    logic [7:0] e8 [4];
    e8 = '{8'h88, 8'h77, 8'h66, 8'h55};
    set_vid(32'h0);
    set_scl(1, 4);
    set_vid(32'h3000_00FF);
    for (int i = 0; i < 4; i++) push_word(32'hA1A2_A3A4 + i, 32'h0);
    tick();
    tick();
    tick();
    checks++; if (pin_out !== 32'h0000_00A3) begin errors++; $display("FAIL dis_mid: got %h expected %h", pin_out, 32'h0000_00A3); end
    set_vid(32'h0);
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL dis_pin: got %h expected 0", pin_out); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dis_ready: got %b expected 0", ready); end
    push_word(32'hDEAD_BEEF, 32'h0);
    tick();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL dis_idle_tick: got %h expected 0", pin_out); end
    set_vid(32'h3000_00FF);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL dis_reenable_ready: got %b expected 1", ready); end
    push_word(32'h5566_7788, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pin_out !== {24'h0, e8[i]}) begin errors++; $display("FAIL dis_new_b%0d: got %h expected %h", i, pin_out, {24'h0, e8[i]}); end
    end
    tick();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL dis_old_discarded: got %h expected 0", pin_out); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL dis_underrun: got %b expected 1", underrun); end
  endtask

  task automatic test_random();
    logic [31:0] v, ep;
    int n, m, target;
    for (int it = 0; it < 6; it++) begin
      m_mode = $urandom_range(0, 3);
      m_cpp  = $urandom_range(1, 3);
      m_cpf  = $urandom_range(1, 12);
      m_k    = $urandom_range(1, 4);
      m_grp  = $urandom_range(0, 3);
      m_mask = 8'($urandom);
      v = (32'($urandom_range(1, 3)) << 29) | (32'(m_mode) << 27) | (32'(m_grp) << 8) | {24'h0, m_mask};
      set_vid(32'h0);
      set_scl(m_cpp, m_cpf);
      set_vid(v);
      for (int i = 0; i < m_k; i++) begin
        m_pix[i] = $urandom;
        m_col[i] = $urandom;
        push_word(m_pix[i], m_col[i]);
      end
      checks++; if (ready !== model_ready(-1)) begin errors++; $display("FAIL rnd%0d_ready_pre: got %b expected %b", it, ready, model_ready(-1)); end
      n = 0;
      target = (m_k + 1) * m_cpf + 2;
      while (n < target) begin
        vid_tick = ($urandom_range(0, 3) != 0);
        cyc();
        if (vid_tick) n++;
        vid_tick = 1'b0;
        m = n - 1;
        ep = model_pin(m);
        checks++; if (pin_out !== ep) begin errors++; $display("FAIL rnd%0d_pin_m%0d: got %h expected %h", it, m, pin_out, ep); end
        checks++; if (underrun !== model_underrun(m)) begin errors++; $display("FAIL rnd%0d_underrun_m%0d: got %b expected %b", it, m, underrun, model_underrun(m)); end
        checks++; if (ready !== model_ready(m)) begin errors++; $display("FAIL rnd%0d_ready_m%0d: got %b expected %b", it, m, ready, model_ready(m)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_1bpp();
    test_2bpp();
    test_8bpp();
    test_fifo_full();
    test_underrun();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
